// File: rtl/fifo_multi_pop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_multi_pop_pkg
//  Description : Shared types and helpers for the four-lane multi-pop FIFO:
//                lane one-hot/count types, bank pointer layout, population
//                count and one-hot rotation.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_multi_pop_pkg;

    localparam int unsigned LANES = 4;

    // Default bank depth; the bank module derives its own pointer width from N.
    localparam int unsigned FMP_N = 8;

    // One bit per lane/bank.
    typedef logic [LANES-1:0] lane_1h_t;

    // Holds a lane count 0..LANES.
    typedef logic [2:0] lane_cnt_t;

    // Bank pointer: address plus a wrap bit so full and empty are distinguishable.
    typedef struct packed {
        logic                     b;
        logic [$clog2(FMP_N)-1:0] mem;
    } fmp_ptr_t;

    // Number of set bits in a lane vector (grant count).
    function automatic lane_cnt_t popcnt(input lane_1h_t v);
        lane_cnt_t c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + lane_cnt_t'(v[i]);
        end
        return c;
    endfunction

    // Rotate a lane vector left by amt positions (amt in 0..LANES).
    function automatic lane_1h_t rotl_1h(input lane_1h_t v, input lane_cnt_t amt);
        logic [2*LANES-1:0] t;
        t = {v, v} << amt;
        return t[2*LANES-1:LANES];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_multi_pop_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_multi_pop_bank
//  Description : One N-deep, W-wide storage bank with its own write/read
//                pointers (wrap-bit form) and local full/empty flags.
//                Read data is the entry at the read pointer (combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_multi_pop_bank #(
    parameter int W = 32,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(N);

    typedef struct packed {
        logic          b;
        logic [AW-1:0] mem;
    } bank_ptr_t;

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    bank_ptr_t    wr_ptr_q, wr_ptr_d;
    bank_ptr_t    rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [N];

    // Local flags from the wrap-bit compare, and pointer advance on access.
    always_comb begin
        full     = (wr_ptr_q.b != rd_ptr_q.b) && (wr_ptr_q.mem == rd_ptr_q.mem);
        empty    = (wr_ptr_q == rd_ptr_q);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en && !full) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_en && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem_q[wr_ptr_q.mem] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q.mem];

endmodule
`default_nettype wire

// File: rtl/fifo_multi_pop.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_multi_pop
//  Description : FIFO with one push port and four pop lanes. Entries are
//                striped round-robin over four banks; up to four of the
//                oldest entries leave per cycle, lane 0 being the oldest.
//                Grants, data and status are all registered.
//                Optional macro FIFO_MULTI_POP_ASSERT_EN compiles in
//                protocol/invariant assertions (no functional effect).
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_multi_pop
    import fifo_multi_pop_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_0,
    input  logic [W-1:0] push_0_data,
    input  logic         pop_0,
    input  logic         pop_1,
    input  logic         pop_2,
    input  logic         pop_3,
    output logic         pop_0_valid_r,
    output logic         pop_1_valid_r,
    output logic         pop_2_valid_r,
    output logic         pop_3_valid_r,
    output logic [W-1:0] pop_0_data_r,
    output logic [W-1:0] pop_1_data_r,
    output logic [W-1:0] pop_2_data_r,
    output logic [W-1:0] pop_3_data_r,
    output logic         full_r,
    output logic         empty_r,
    output logic [3:0]   avail_r
);

    localparam int CAP   = LANES * N;
    localparam int OCC_W = $clog2(CAP) + 1;
    localparam logic [OCC_W-1:0] OCC_CAP = OCC_W'(CAP);

    // Registered state
    lane_1h_t         push_idx_q, push_idx_d;
    lane_1h_t         pop_idx_q,  pop_idx_d;
    logic [OCC_W-1:0] occ_q,      occ_d;
    logic             full_q,     full_d;
    logic             empty_q,    empty_d;
    lane_1h_t         avail_q,    avail_d;
    lane_1h_t         valid_q,    valid_d;
    logic [W-1:0]     data_q [LANES];

    // Combinational
    lane_1h_t         w_pop;
    lane_1h_t         w_grant;
    lane_1h_t         w_sel [LANES];
    lane_1h_t         w_rd_en;
    lane_1h_t         w_wr_en;
    logic             w_push_acc;
    lane_cnt_t        w_gcnt;
    logic [W-1:0]     w_lane_data [LANES];
    logic [W-1:0]     w_bank_rdata [LANES];
    lane_1h_t         w_bank_full;
    lane_1h_t         w_bank_empty;

    assign w_pop = {pop_3, pop_2, pop_1, pop_0};

    generate
        for (genvar b = 0; b < LANES; b++) begin : g_bank
            fifo_multi_pop_bank #(
                .W (W),
                .N (N)
            ) u_bank (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (w_wr_en[b]),
                .wr_data (push_0_data),
                .rd_en   (w_rd_en[b]),
                .rd_data (w_bank_rdata[b]),
                .full    (w_bank_full[b]),
                .empty   (w_bank_empty[b])
            );
        end
    endgenerate

    // Grant chain: a lane wins only if every lower lane won, so gaps in the
    // request vector truncate the grant. Lane i maps to bank pop_idx rotated by i.
    always_comb begin
        logic chain;
        chain   = 1'b1;
        w_grant = '0;
        w_rd_en = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sel[i]       = rotl_1h(pop_idx_q, lane_cnt_t'(i));
            w_grant[i]     = chain & w_pop[i] & avail_q[i] & ~|(w_sel[i] & w_bank_empty);
            chain          = w_grant[i];
            w_rd_en        = w_rd_en | (w_sel[i] & {LANES{w_grant[i]}});
            w_lane_data[i] = '0;
            for (int b = 0; b < LANES; b++) begin
                if (w_sel[i][b]) begin
                    w_lane_data[i] = w_bank_rdata[b];
                end
            end
        end
        w_gcnt = popcnt(w_grant);
    end

    // Push acceptance and next-state of indices, occupancy and status.
    always_comb begin
        w_push_acc = push_0 & ~full_q & ~|(push_idx_q & w_bank_full);
        w_wr_en    = push_idx_q & {LANES{w_push_acc}};
        push_idx_d = w_push_acc ? rotl_1h(push_idx_q, lane_cnt_t'(1)) : push_idx_q;
        pop_idx_d  = rotl_1h(pop_idx_q, w_gcnt);
        occ_d      = occ_q + {{(OCC_W-1){1'b0}}, w_push_acc}
                           - {{(OCC_W-3){1'b0}}, w_gcnt};
        full_d     = (occ_d == OCC_CAP);
        empty_d    = (occ_d == '0);
        for (int i = 0; i < LANES; i++) begin
            avail_d[i] = (occ_d > OCC_W'(i));
        end
        valid_d    = w_grant;
    end

    // Control and status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            push_idx_q <= 4'b0001;
            pop_idx_q  <= 4'b0001;
            occ_q      <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            avail_q    <= '0;
            valid_q    <= '0;
        end else begin
            push_idx_q <= push_idx_d;
            pop_idx_q  <= pop_idx_d;
            occ_q      <= occ_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            avail_q    <= avail_d;
            valid_q    <= valid_d;
        end
    end

    // Lane data registers; only meaningful alongside valid, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (w_grant[i]) begin
                data_q[i] <= w_lane_data[i];
            end
        end
    end

    assign pop_0_valid_r = valid_q[0];
    assign pop_1_valid_r = valid_q[1];
    assign pop_2_valid_r = valid_q[2];
    assign pop_3_valid_r = valid_q[3];
    assign pop_0_data_r  = data_q[0];
    assign pop_1_data_r  = data_q[1];
    assign pop_2_data_r  = data_q[2];
    assign pop_3_data_r  = data_q[3];
    assign full_r        = full_q;
    assign empty_r       = empty_q;
    assign avail_r       = avail_q;

`ifdef FIFO_MULTI_POP_ASSERT_EN
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(push_0 && full_q));
    a_pop_thermometer: assert property (@(posedge clk) disable iff (!rst)
        ((w_pop & (w_pop + lane_1h_t'(1))) == '0));
    a_pop_within_avail: assert property (@(posedge clk) disable iff (!rst)
        ((w_pop & ~avail_q) == '0));
    a_occ_bounded: assert property (@(posedge clk) disable iff (!rst)
        (occ_q <= OCC_CAP));
    a_avail_thermometer: assert property (@(posedge clk) disable iff (!rst)
        ((avail_q & (avail_q + lane_1h_t'(1))) == '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_multi_pop.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_multi_pop
//  Description : Self-checking bench for fifo_multi_pop against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_multi_pop;

    localparam int W   = 32;
    localparam int N   = 8;
    localparam int CAP = 4 * N;

    logic         clk;
    logic         rst;
    logic         push_0;
    logic [W-1:0] push_0_data;
    logic         pop_0, pop_1, pop_2, pop_3;
    logic         pop_0_valid_r, pop_1_valid_r, pop_2_valid_r, pop_3_valid_r;
    logic [W-1:0] pop_0_data_r, pop_1_data_r, pop_2_data_r, pop_3_data_r;
    logic         full_r;
    logic         empty_r;
    logic [3:0]   avail_r;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] model_q [$];

    fifo_multi_pop #(.W(W), .N(N)) dut (
        .clk           (clk),
        .rst           (rst),
        .push_0        (push_0),
        .push_0_data   (push_0_data),
        .pop_0         (pop_0),
        .pop_1         (pop_1),
        .pop_2         (pop_2),
        .pop_3         (pop_3),
        .pop_0_valid_r (pop_0_valid_r),
        .pop_1_valid_r (pop_1_valid_r),
        .pop_2_valid_r (pop_2_valid_r),
        .pop_3_valid_r (pop_3_valid_r),
        .pop_0_data_r  (pop_0_data_r),
        .pop_1_data_r  (pop_1_data_r),
        .pop_2_data_r  (pop_2_data_r),
        .pop_3_data_r  (pop_3_data_r),
        .full_r        (full_r),
        .empty_r       (empty_r),
        .avail_r       (avail_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] lane_data(input int i);
        case (i)
            0:       return pop_0_data_r;
            1:       return pop_1_data_r;
            2:       return pop_2_data_r;
            default: return pop_3_data_r;
        endcase
    endfunction

    task automatic check_status(input string tag);
        int sz;
        logic [3:0] ea;
        sz = model_q.size();
        for (int i = 0; i < 4; i++) ea[i] = (sz > i);
        check({tag, ".empty"}, 32'(empty_r), 32'(sz == 0));
        check({tag, ".full"},  32'(full_r),  32'(sz == CAP));
        check({tag, ".avail"}, 32'(avail_r), 32'(ea));
    endtask

    // One clock: drive request, predict grants from the queue, compare after the edge.
    task automatic cycle(input logic push, input logic [W-1:0] pdata, input logic [3:0] pop);
        int sz, g;
        logic acc;
        logic [W-1:0] exp_d [4];
        logic [3:0] ev;
        sz = model_q.size();
        g  = 0;
        for (int i = 0; i < 4; i++) begin
            if (pop[i] && (i < sz) && (g == i)) g++;
        end
        acc = push && (sz < CAP);
        for (int i = 0; i < g; i++) exp_d[i] = model_q[i];
        ev = 4'((1 << g) - 1);

        push_0      = push;
        push_0_data = pdata;
        {pop_3, pop_2, pop_1, pop_0} = pop;
        @(posedge clk);
        #1;
        check("valid", 32'({pop_3_valid_r, pop_2_valid_r, pop_1_valid_r, pop_0_valid_r}), 32'(ev));
        for (int i = 0; i < g; i++) check("data", lane_data(i), exp_d[i]);
        for (int i = 0; i < g; i++) void'(model_q.pop_front());
        if (acc) model_q.push_back(pdata);
        check_status("status");
    endtask

    task automatic idle_inputs();
        push_0 = 1'b0;
        push_0_data = '0;
        {pop_3, pop_2, pop_1, pop_0} = 4'b0000;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.empty", 32'(empty_r), 32'd1);
        check("rst.full",  32'(full_r),  32'd0);
        check("rst.avail", 32'(avail_r), 32'd0);
        check("rst.valid", 32'({pop_3_valid_r, pop_2_valid_r, pop_1_valid_r, pop_0_valid_r}), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Ordered multi-pop
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'h10 + 32'(i), 4'b0000);
        cycle(1'b0, '0, 4'b1111);
        check("ord.avail", 32'(avail_r), 32'b0001);
        cycle(1'b0, '0, 4'b0001);
        check("ord.d0", pop_0_data_r, 32'h14);
        check("ord.empty", 32'(empty_r), 32'd1);

        // Partial grant and truncation
        for (int i = 0; i < 2; i++) cycle(1'b1, 32'h20 + 32'(i), 4'b0000);
        cycle(1'b0, '0, 4'b1111);
        check("part.valid", 32'({pop_3_valid_r, pop_2_valid_r, pop_1_valid_r, pop_0_valid_r}), 32'b0011);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h30 + 32'(i), 4'b0000);
        cycle(1'b0, '0, 4'b1101);
        check("trunc.valid", 32'({pop_3_valid_r, pop_2_valid_r, pop_1_valid_r, pop_0_valid_r}), 32'b0001);
        cycle(1'b0, '0, 4'b1111);

        // Fill, drop at full, drain in order
        for (int i = 0; i < CAP; i++) cycle(1'b1, 32'h100 + 32'(i), 4'b0000);
        check("full.full",  32'(full_r),  32'd1);
        check("full.avail", 32'(avail_r), 32'b1111);
        cycle(1'b1, 32'hFF, 4'b0000);
        for (int i = 0; i < CAP / 4; i++) cycle(1'b0, '0, 4'b1111);
        check("drain.empty", 32'(empty_r), 32'd1);

        // Simultaneous push/pop at full
        for (int i = 0; i < CAP; i++) cycle(1'b1, 32'h200 + 32'(i), 4'b0000);
        cycle(1'b1, 32'h55, 4'b0011);
        check("sim.full", 32'(full_r), 32'd0);
        cycle(1'b1, 32'h55, 4'b0000);
        for (int i = 0; i < CAP / 4; i++) cycle(1'b0, '0, 4'b1111);
        check("sim.last", pop_2_data_r, 32'h55);

        // Reset mid-run with 5 entries held and a valid pulse in flight
        for (int i = 0; i < 6; i++) cycle(1'b1, 32'h300 + 32'(i), 4'b0000);
        cycle(1'b0, '0, 4'b0001);
        #2;
        rst = 1'b0;
        #1;
        model_q.delete();
        check("mrst.empty", 32'(empty_r), 32'd1);
        check("mrst.full",  32'(full_r),  32'd0);
        check("mrst.avail", 32'(avail_r), 32'd0);
        check("mrst.valid", 32'({pop_3_valid_r, pop_2_valid_r, pop_1_valid_r, pop_0_valid_r}), 32'd0);
        {pop_3, pop_2, pop_1, pop_0} = 4'b1111;
        @(posedge clk);
        #1;
        check("mrst.hold", 32'({pop_3_valid_r, pop_2_valid_r, pop_1_valid_r, pop_0_valid_r}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 32'hA5, 4'b0000);
        cycle(1'b0, '0, 4'b0001);
        check("mrst.a5", pop_0_data_r, 32'hA5);

        // Random soak with phases biased toward filling or draining
        for (int k = 0; k < 10000; k++) begin
            logic       p;
            logic [3:0] pv;
            int         n;
            if (((k / 400) % 2) == 0) p = ($urandom_range(0, 7) < 7);
            else                      p = ($urandom_range(0, 7) < 3);
            n  = $urandom_range(0, 4);
            pv = 4'((1 << n) - 1);
            if ($urandom_range(0, 7) == 0) pv = 4'($urandom_range(0, 15));
            cycle(p, $urandom, pv);
        end

        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
